// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU result checker and its reference
// model.
//   DEF_WIDTH   default operand/sum width
//   MASK_W      width of the per-vector mismatch mask
//   MSK_*       bit positions inside the mismatch mask {sum, ovf, negf, zf, carf}
//   chk_state_t checker FSM states
//   flags_t     ALU flag bundle
package alu_chk_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int MASK_W    = 5;

  localparam int MSK_CARF = 0;
  localparam int MSK_ZF   = 1;
  localparam int MSK_NEGF = 2;
  localparam int MSK_OVF  = 3;
  localparam int MSK_SUM  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic ovf;
    logic negf;
    logic zf;
    logic carf;
  } flags_t;
endpackage

// File: rtl/alu_result_checker_if.sv
// Operand/result stream between the ALU stimulus side (master) and the
// result checker (slave).
//   in_valid/in_ready  handshake; a bundle moves when both are high
//   a, b               operands
//   dut_sum, dut_*     sum and flags observed on the ALU under test
interface alu_result_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_ovf;
  logic             dut_negf;
  logic             dut_zf;
  logic             dut_carf;

  modport master (
    output in_valid, a, b, dut_sum, dut_ovf, dut_negf, dut_zf, dut_carf,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, dut_sum, dut_ovf, dut_negf, dut_zf, dut_carf,
    output in_ready
  );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational reference for the 4-bit ALU add: produces the expected sum
// and the overflow/negative/zero/carry flags for an operand pair.
//   a, b   operands
//   sum    (a+b) mod 2^WIDTH
//   flags  expected {ovf, negf, zf, carf}
module alu_ref_model
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output flags_t           flags
);
  logic [WIDTH:0] full;

  always_comb begin
    full       = {1'b0, a} + {1'b0, b};
    sum        = full[WIDTH-1:0];
    flags.carf = full[WIDTH];
    // Signed overflow: like-signed operands producing a result of the other sign.
    flags.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    flags.negf = full[WIDTH-1];
    flags.zf   = (full[WIDTH-1:0] == '0);
  end
endmodule

// File: rtl/alu_result_checker.sv
// Checks a stream of ALU operand/result bundles against a reference model.
// Counts matching and mismatching vectors and captures the first failure.
//   clk, rst          clock, synchronous active-high reset
//   start             begins a run (honoured in IDLE/DONE)
//   num_vectors       vectors in the run, latched on start
//   bus               operand/result stream (slave side)
//   busy, done        RUN/DRAIN, DONE status
//   pass_count        matching vectors (saturating)
//   fail_count        mismatching vectors (saturating)
//   first_fail_*      operands and {sum,ovf,negf,zf,carf} mask of first failure
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vectors,
  alu_result_checker_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic                first_fail_valid,
  output logic [WIDTH-1:0]    first_fail_a,
  output logic [WIDTH-1:0]    first_fail_b,
  output logic [MASK_W-1:0]   first_fail_mask
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [MASK_W-1:0] mismatch_mask(
    input logic [WIDTH-1:0] ds, input logic [WIDTH-1:0] es,
    input flags_t df, input flags_t ef);
    logic [MASK_W-1:0] m;
    m           = '0;
    m[MSK_SUM]  = (ds != es);
    m[MSK_OVF]  = (df.ovf  != ef.ovf);
    m[MSK_NEGF] = (df.negf != ef.negf);
    m[MSK_ZF]   = (df.zf   != ef.zf);
    m[MSK_CARF] = (df.carf != ef.carf);
    return m;
  endfunction

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] num_q, acc_cnt;
  logic             in_ready_c, run_start, accept, last_acc;
  logic             vld_p1, vld_p2;

  logic [WIDTH-1:0]  exp_sum;
  flags_t            exp_flags;
  logic [WIDTH-1:0]  a_p1, b_p1, dut_sum_p1, exp_sum_p1;
  flags_t            dut_flags_p1, exp_flags_p1;
  logic [WIDTH-1:0]  a_p2, b_p2;
  logic [MASK_W-1:0] mask_p2;

  assign bus.in_ready = in_ready_c;
  assign accept       = bus.in_valid && in_ready_c;
  assign last_acc     = ((acc_cnt + CNT_W'(1)) == num_q);

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    run_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_d   = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        if (accept && last_acc) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!vld_p1 && !vld_p2) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          run_start = 1'b1;
          state_d   = (num_vectors == '0) ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a     (bus.a),
    .b     (bus.b),
    .sum   (exp_sum),
    .flags (exp_flags)
  );

  // Stage p1: capture the accepted bundle alongside its expected result
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1         <= bus.a;
      b_p1         <= bus.b;
      dut_sum_p1   <= bus.dut_sum;
      dut_flags_p1 <= '{ovf: bus.dut_ovf, negf: bus.dut_negf,
                         zf: bus.dut_zf, carf: bus.dut_carf};
      exp_sum_p1   <= exp_sum;
      exp_flags_p1 <= exp_flags;
    end
    // Stage p2: field-by-field comparison
    if (vld_p1) begin
      mask_p2 <= mismatch_mask(dut_sum_p1, exp_sum_p1, dut_flags_p1, exp_flags_p1);
      a_p2    <= a_p1;
      b_p2    <= b_p1;
    end
  end

  // Control: FSM, valid pipe, accept count, result counters, first-fail capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      num_q            <= '0;
      acc_cnt          <= '0;
      vld_p1           <= 1'b0;
      vld_p2           <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_mask  <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= accept;
      vld_p2  <= vld_p1;
      // A run only starts from IDLE/DONE, where the pipeline is empty,
      // so clearing here cannot drop an in-flight result.
      if (run_start) begin
        num_q            <= num_vectors;
        acc_cnt          <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_a     <= '0;
        first_fail_b     <= '0;
        first_fail_mask  <= '0;
      end else begin
        if (accept) acc_cnt <= sat_inc(acc_cnt);
        if (vld_p2) begin
          if (mask_p2 == '0) begin
            pass_count <= sat_inc(pass_count);
          end else begin
            fail_count <= sat_inc(fail_count);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_a     <= a_p2;
              first_fail_b     <= b_p2;
              first_fail_mask  <= mask_p2;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_vectors;
  logic       busy, done, first_fail_valid;
  logic [7:0] pass_count, fail_count;
  logic [3:0] first_fail_a, first_fail_b;
  logic [4:0] first_fail_mask;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_checker_if #(.WIDTH(4)) bus ();

  alu_result_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_vectors      (num_vectors),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_a     (first_fail_a),
    .first_fail_b     (first_fail_b),
    .first_fail_mask  (first_fail_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving happens on the falling edge; DUT state is stable there.
  task automatic start_run(input logic [7:0] n);
    start       = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one bundle and returns on the falling edge after it was taken.
  // in_valid is left high so consecutive calls are back-to-back.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                      input logic ovf, input logic negf, input logic zf, input logic carf);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.dut_sum  = s;
    bus.dut_ovf  = ovf;
    bus.dut_negf = negf;
    bus.dut_zf   = zf;
    bus.dut_carf = carf;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int acc;
    int pat[6];
    pat = '{1, 0, 1, 1, 0, 1};
    rst = 1'b1; start = 1'b0; num_vectors = '0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.dut_sum = '0;
    bus.dut_ovf = 1'b0; bus.dut_negf = 1'b0; bus.dut_zf = 1'b0; bus.dut_carf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    chk("rst_pass",     {24'd0, pass_count}, 32'd0);
    chk("rst_fail",     {24'd0, fail_count}, 32'd0);
    chk("rst_ffv",      {31'd0, first_fail_valid}, 32'd0);

    // 1: single good vector, 6+2=8 with ovf and negf set
    start_run(8'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(4'b0110, 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    chk("t1_ready_after", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_pass_n2", {24'd0, pass_count}, 32'd1);
    chk("t1_done_n2", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t1_done_n3", {31'd0, done}, 32'd1);
    chk("t1_fail", {24'd0, fail_count}, 32'd0);
    chk("t1_ffv", {31'd0, first_fail_valid}, 32'd0);

    // 2: three back-to-back, middle one with carry flag forced low
    start_run(8'd3);
    send(4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'b0111, 4'b0001, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    chk("t2_ready_after", {31'd0, bus.in_ready}, 32'd0);
    wait_done("t2_done");
    chk("t2_pass", {24'd0, pass_count}, 32'd2);
    chk("t2_fail", {24'd0, fail_count}, 32'd1);
    chk("t2_ffv",  {31'd0, first_fail_valid}, 32'd1);
    chk("t2_ffa",  {28'd0, first_fail_a}, 32'hF);
    chk("t2_ffb",  {28'd0, first_fail_b}, 32'h1);
    chk("t2_mask", {27'd0, first_fail_mask}, 32'b00001);

    // 3: zero-length run goes straight to DONE and clears the counts
    start_run(8'd0);
    chk("t3_done",  {31'd0, done}, 32'd1);
    chk("t3_busy",  {31'd0, busy}, 32'd0);
    chk("t3_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t3_pass",  {24'd0, pass_count}, 32'd0);
    chk("t3_fail",  {24'd0, fail_count}, 32'd0);
    chk("t3_ffv",   {31'd0, first_fail_valid}, 32'd0);

    // 4: gapped valid, then extra valid once the run is full
    start_run(8'd4);
    bus.a = 4'b0011; bus.b = 4'b0100; bus.dut_sum = 4'b0111;
    bus.dut_ovf = 1'b0; bus.dut_negf = 1'b0; bus.dut_zf = 1'b0; bus.dut_carf = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = (i < 6) ? pat[i][0] : 1'b1;
      if (bus.in_valid && bus.in_ready) acc++;
      @(negedge clk);
    end
    chk("t4_accepts", acc, 32'd4);
    chk("t4_ready",   {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    wait_done("t4_done");
    chk("t4_pass", {24'd0, pass_count}, 32'd4);
    chk("t4_fail", {24'd0, fail_count}, 32'd0);

    // 5: reset in the middle of a run
    start_run(8'd5);
    send(4'b0001, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_ffv_before", {31'd0, first_fail_valid}, 32'd1);
    chk("t5_fail_before", {24'd0, fail_count}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy",  {31'd0, busy}, 32'd0);
    chk("t5_done",  {31'd0, done}, 32'd0);
    chk("t5_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t5_pass",  {24'd0, pass_count}, 32'd0);
    chk("t5_fail",  {24'd0, fail_count}, 32'd0);
    chk("t5_ffv",   {31'd0, first_fail_valid}, 32'd0);
    chk("t5_ffa",   {28'd0, first_fail_a}, 32'd0);
    chk("t5_mask",  {27'd0, first_fail_mask}, 32'd0);

    // 6: 255 sum mismatches, then restart with a single good vector
    start_run(8'd255);
    for (int i = 0; i < 255; i++)
      send(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_fail", {24'd0, fail_count}, 32'd255);
    chk("t6_pass", {24'd0, pass_count}, 32'd0);
    chk("t6_mask", {27'd0, first_fail_mask}, 32'b10000);
    start_run(8'd1);
    chk("t6_fail_clr", {24'd0, fail_count}, 32'd0);
    chk("t6_ffv_clr",  {31'd0, first_fail_valid}, 32'd0);
    send(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    wait_done("t6_done2");
    chk("t6_pass2", {24'd0, pass_count}, 32'd1);
    chk("t6_fail2", {24'd0, fail_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Response-side companion to the 4-bit ALU: it is the reader of the operand/result stream that the ALU stimulus side writes.
- Accepts operand pairs together with the ALU's observed sum and flags over a valid/ready handshake. Recomputes the expected result in a reference model and compares it field by field.
- Accumulates pass/fail counts and latches the first failing vector. Sits beside the ALU instance in the team's ALU bench and self-test harness.

Parameters:
- WIDTH, 4, operand and sum width in bits.
- CNT_W, 8, width of the vector-count, pass and fail counters.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run. Sampled in IDLE or DONE.
- num_vectors  input  CNT_W  number of vectors in the run; latched on start.
- in_valid  input  1  operand/result bundle present on the inputs.
- in_ready  output  1  checker accepts a bundle this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- dut_sum  input  WIDTH  ALU sum output.
- dut_ovf, dut_negf, dut_zf, dut_carf  input  1 each  ALU overflow, negative, zero and carry flags.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass_count  output  CNT_W  vectors that matched.
- fail_count  output  CNT_W  vectors that mismatched.
- first_fail_valid  output  1  sticky; a failure has been latched.
- first_fail_a, first_fail_b  output  WIDTH  operands of the first failure.
- first_fail_mask  output  5  mismatch bits of the first failure: {sum, ovf, negf, zf, carf}. The sum bit is set if any sum bit differs.

Behaviour:
- Reference arithmetic, using a WIDTH+1-bit add:
  - exp_sum = (a+b) mod 2^WIDTH
  - exp_carf = bit WIDTH of the add
  - exp_ovf = (a[MSB]==b[MSB]) && (exp_sum[MSB]!=a[MSB])
  - exp_negf = exp_sum[MSB]
  - exp_zf = (exp_sum==0)
- Reset: state IDLE. in_ready=0, busy=0, done=0. All counters 0. first_fail_valid=0 and all first_fail_* fields 0. Pipeline valid bits 0. A reset mid-run aborts the run and clears everything in the same cycle.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start with num_vectors!=0.
  - IDLE -> DONE on start with num_vectors==0. Counters stay 0.
  - RUN: in_ready=1. A bundle is accepted when in_valid && in_ready. The internal accepted counter increments on each accept.
  - RUN -> DRAIN in the cycle after the accept that makes the accepted count equal the latched num_vectors. in_ready is 0 from that next cycle onward.
  - DRAIN -> DONE once both pipeline stages are empty.
  - DONE: done held high. start here clears the counters and first_fail_* and re-enters RUN (or DONE if num_vectors==0).
  - start is ignored in RUN and DRAIN.
- Pipeline, two stages:
  - S1 registers a, b, the DUT outputs and the expected values on accept.
  - S2 registers the 5-bit mismatch mask.
  - Counter update is registered from S2. A vector accepted at edge N is reflected in pass_count or fail_count after edge N+2.
- Full-throughput back-to-back accepts are supported; there is no bubble.
- Counters saturate at 2^CNT_W-1 and do not wrap. The accepted counter cannot exceed num_vectors.
- first_fail_* is written only when first_fail_valid is 0 and an S2 mask is nonzero. Later failures only increment fail_count.
- in_valid while in_ready=0 is ignored; no data is latched.

Decomposition:
- Package alu_chk_pkg holds:
  - WIDTH default constant.
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Flag-bundle typedef {ovf, negf, zf, carf}.
  - Mismatch-mask bit-index constants.
- Sub-module alu_ref_model: purely combinational reference adder and flag generator. It is instanced in S1 and reusable by other benches.

Test Plan:
1. num_vectors=1; a=0110, b=0010; DUT sum=1000, ovf=1, negf=1, zf=0, carf=0 -> pass_count=1, fail_count=0, done high 3 cycles after accept, first_fail_valid=0.
2. num_vectors=3, back-to-back accepts; vector 2 is a=1111, b=0001 with DUT carf forced 0 (expected sum 0000, zf=1, carf=1) -> pass=2, fail=1; first_fail_a=1111, first_fail_b=0001, mask=00001.
3. num_vectors=0 with start -> DONE the next cycle; counts 0; in_ready never asserted.
4. num_vectors=4 with in_valid toggling 1,0,1,1,0,1 -> exactly 4 accepts; in_ready=0 after the 4th accept; extra in_valid ignored.
5. rst asserted mid-run after 2 accepts -> next cycle IDLE, counters 0, in_ready=0, first_fail_valid=0.
6. num_vectors=255, all vectors mismatching on sum, then a restart in DONE -> fail_count=255 and saturated; restart clears it and a single good vector gives pass=1.
